// File: rtl/game_ctrl_fsm.sv
// Game-flow controller for the loop-it-in arcade datapath: one-hot state register,
// lives counter, tick-driven penalty timer, pushbutton edge detection and a PAUSE mode.
module game_ctrl_fsm #(
    parameter int NUM_LIVES     = 3,
    parameter int LIVES_W       = 2,
    parameter int PENALTY_TICKS = 4,
    parameter int TIMER_W       = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pb1,
    input  logic               pb2,
    input  logic               tick,
    input  logic               collision,
    input  logic               paddlegone,
    output logic [6:0]         state,
    output logic [LIVES_W-1:0] lives,
    output logic [TIMER_W-1:0] timer,
    output logic               movecarpet,
    output logic               moveball,
    output logic               movepaddle,
    output logic               paddlehide,
    output logic               resetpositions,
    output logic               decrementlives,
    output logic               game_over
);

    typedef enum logic [6:0] {
        S_STARTGAME  = 7'b0000001,
        S_IDLE       = 7'b0000010,
        S_PLAY       = 7'b0000100,
        S_FLASH      = 7'b0001000,
        S_PADDLEFALL = 7'b0010000,
        S_NOPADDLES  = 7'b0100000,
        S_PAUSE      = 7'b1000000
    } state_t;

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PENALTY_TICKS - 1);

    state_t             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               pb1_q, pb1_d, pb2_q, pb2_d;
    logic               pb1_arm_q, pb1_arm_d, pb2_arm_q, pb2_arm_d;
    logic               pb1_rise, pb2_rise;

    // A button already held while reset is asserted stays disarmed until it is released.
    always_comb begin
        pb1_d     = pb1;
        pb2_d     = pb2;
        pb1_arm_d = reset ? ~pb1 : (pb1_arm_q | ~pb1);
        pb2_arm_d = reset ? ~pb2 : (pb2_arm_q | ~pb2);
        pb1_rise  = pb1 & ~pb1_q & pb1_arm_q;
        pb2_rise  = pb2 & ~pb2_q & pb2_arm_q;
    end

    always_comb begin
        state_d        = state_q;
        lives_d        = lives_q;
        timer_d        = timer_q;
        decrementlives = 1'b0;
        game_over      = 1'b0;
        case (state_q)
            S_STARTGAME: begin
                if (pb2_rise) begin
                    state_d = S_PLAY;
                    lives_d = LIVES_INIT;
                end
            end
            S_IDLE: begin
                if (pb2_rise) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (collision || paddlegone) begin
                    state_d        = collision ? S_FLASH : S_PADDLEFALL;
                    lives_d        = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
                    timer_d        = '0;
                    decrementlives = 1'b1;
                end else if (pb1_rise) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (pb1_rise) state_d = S_PLAY;
            end
            S_FLASH, S_PADDLEFALL: begin
                if (tick) begin
                    if (timer_q == TIMER_LAST) begin
                        timer_d = '0;
                        if (lives_q == '0) begin
                            state_d   = S_NOPADDLES;
                            game_over = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            S_NOPADDLES: begin
                if (pb1_rise) state_d = S_STARTGAME;
            end
            default: state_d = S_STARTGAME;
        endcase
        // Reset aborts the transition in flight, so its pulses must not escape.
        if (reset) begin
            decrementlives = 1'b0;
            game_over      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_STARTGAME;
            lives_q <= LIVES_INIT;
            timer_q <= '0;
            pb1_q   <= 1'b0;
            pb2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            timer_q <= timer_d;
            pb1_q   <= pb1_d;
            pb2_q   <= pb2_d;
        end
        pb1_arm_q <= pb1_arm_d;
        pb2_arm_q <= pb2_arm_d;
    end

    always_comb begin
        state          = state_q;
        lives          = lives_q;
        timer          = timer_q;
        movecarpet     = state_q[2] | state_q[3] | state_q[4] | state_q[5];
        moveball       = state_q[2] | state_q[3] | state_q[4] | state_q[5];
        movepaddle     = state_q[2] | state_q[3] | state_q[4];
        paddlehide     = state_q[5];
        resetpositions = state_q[0] | state_q[1];
    end

endmodule
